axis_dest_demux: RTL

AXIS_DEST_DEMUX -- requirements
Module: axis_dest_demux

---
 rtl/axis_demux_pkg.sv | 20 ++
 rtl/axis_skid_reg.sv | 72 +++++++
 rtl/axis_dest_demux.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/axis_demux_pkg.sv
// Shared definitions for the AXI stream destination demultiplexer.
package axis_demux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUTE = 2'd1,
    ST_DROP  = 2'd2
  } demux_state_t;

  function automatic int unsigned cl_m_count(input int unsigned m_count);
    return (m_count > 1) ? $clog2(m_count) : 1;
  endfunction

  // Output tdest keeps the bits below the routing field, never narrower than 1 bit.
  function automatic int unsigned m_dest_width(input int unsigned s_dest_width,
                                               input int unsigned m_count);
    return (s_dest_width > cl_m_count(m_count)) ? s_dest_width - cl_m_count(m_count) : 1;
  endfunction

endpackage

// File: rtl/axis_skid_reg.sv
// Output register plus one skid register; ready_int is registered so the
// upstream ready path never sees the downstream ready combinationally.
module axis_skid_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             ready_int,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [WIDTH-1:0] temp_data;
  logic             temp_valid;
  logic             out_valid_next;
  logic             temp_valid_next;
  logic             ready_early;
  logic             store_in_to_out;
  logic             store_in_to_temp;
  logic             store_temp_to_out;

  // Ready next cycle unless both registers could be occupied.
  assign ready_early = out_ready || (!temp_valid && (!out_valid || !in_valid));

  always_comb begin
    out_valid_next    = out_valid;
    temp_valid_next   = temp_valid;
    store_in_to_out   = 1'b0;
    store_in_to_temp  = 1'b0;
    store_temp_to_out = 1'b0;
    if (ready_int) begin
      if (out_ready || !out_valid) begin
        out_valid_next  = in_valid;
        store_in_to_out = 1'b1;
      end else begin
        temp_valid_next  = in_valid;
        store_in_to_temp = 1'b1;
      end
    end else if (out_ready) begin
      out_valid_next    = temp_valid;
      temp_valid_next   = 1'b0;
      store_temp_to_out = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      temp_valid <= 1'b0;
      ready_int  <= 1'b0;
    end else begin
      out_valid  <= out_valid_next;
      temp_valid <= temp_valid_next;
      ready_int  <= ready_early;
    end
  end

  always_ff @(posedge clk) begin
    if (store_in_to_out) begin
      out_data <= in_data;
    end else if (store_temp_to_out) begin
      out_data <= temp_data;
    end
    if (store_in_to_temp) begin
      temp_data <= in_data;
    end
  end

endmodule

// File: rtl/axis_dest_demux.sv
// AXI stream demultiplexer routing whole frames by the top bits of tdest;
// frames addressed beyond M_COUNT are consumed and counted.
module axis_dest_demux
  import axis_demux_pkg::*;
#(
  parameter int unsigned M_COUNT      = 4,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter bit          KEEP_ENABLE  = (DATA_WIDTH > 8),
  parameter int unsigned KEEP_WIDTH   = DATA_WIDTH / 8,
  parameter bit          ID_ENABLE    = 1'b0,
  parameter int unsigned ID_WIDTH     = 8,
  parameter int unsigned S_DEST_WIDTH = cl_m_count(M_COUNT) + 4,
  parameter int unsigned M_DEST_WIDTH = m_dest_width(S_DEST_WIDTH, M_COUNT),
  parameter bit          USER_ENABLE  = 1'b1,
  parameter int unsigned USER_WIDTH   = 1,
  parameter bit          LAST_ENABLE  = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [DATA_WIDTH-1:0]        s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]        s_axis_tkeep,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  input  logic                         s_axis_tlast,
  input  logic [ID_WIDTH-1:0]          s_axis_tid,
  input  logic [S_DEST_WIDTH-1:0]      s_axis_tdest,
  input  logic [USER_WIDTH-1:0]        s_axis_tuser,
  output logic [M_COUNT*DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [M_COUNT*KEEP_WIDTH-1:0]   m_axis_tkeep,
  output logic [M_COUNT-1:0]              m_axis_tvalid,
  input  logic [M_COUNT-1:0]              m_axis_tready,
  output logic [M_COUNT-1:0]              m_axis_tlast,
  output logic [M_COUNT*ID_WIDTH-1:0]     m_axis_tid,
  output logic [M_COUNT*M_DEST_WIDTH-1:0] m_axis_tdest,
  output logic [M_COUNT*USER_WIDTH-1:0]   m_axis_tuser,
  output logic [15:0]                     drop_count
);

  localparam int unsigned CL_M_COUNT = cl_m_count(M_COUNT);
  localparam int unsigned PW = CL_M_COUNT + DATA_WIDTH + KEEP_WIDTH + 1 + ID_WIDTH
                               + M_DEST_WIDTH + USER_WIDTH;
  localparam logic [CL_M_COUNT:0] M_COUNT_W = (CL_M_COUNT + 1)'(M_COUNT);

  demux_state_t state, state_next;
  logic [CL_M_COUNT-1:0] sel_reg, sel_next, first_sel, cur_sel;
  logic first_in_range;
  logic drop_beat, drop_start;
  logic running, ready_int, accept, beat_last;

  logic [PW-1:0] in_payload, out_payload;
  logic          out_valid, out_ready;
  logic [CL_M_COUNT-1:0]   out_sel;
  logic [DATA_WIDTH-1:0]   out_tdata;
  logic [KEEP_WIDTH-1:0]   out_tkeep, keep_in;
  logic                    out_tlast, last_in;
  logic [ID_WIDTH-1:0]     out_tid, id_in;
  logic [M_DEST_WIDTH-1:0] out_tdest, dest_in;
  logic [USER_WIDTH-1:0]   out_tuser, user_in;

  assign first_sel      = s_axis_tdest[S_DEST_WIDTH-1 -: CL_M_COUNT];
  assign first_in_range = {1'b0, first_sel} < M_COUNT_W;
  assign beat_last      = LAST_ENABLE ? s_axis_tlast : 1'b1;

  // Dropped beats bypass the output register, so they are accepted regardless of ready_int.
  assign s_axis_tready = running && (drop_beat || ready_int);
  assign accept        = s_axis_tvalid && s_axis_tready;

  always_comb begin
    state_next = state;
    sel_next   = sel_reg;
    cur_sel    = sel_reg;
    drop_beat  = 1'b0;
    drop_start = 1'b0;
    case (state)
      ST_IDLE: begin
        cur_sel    = first_sel;
        drop_beat  = !first_in_range;
        drop_start = !first_in_range;
        if (accept) begin
          sel_next = first_sel;
          if (!beat_last) state_next = first_in_range ? ST_ROUTE : ST_DROP;
        end
      end
      ST_ROUTE: begin
        if (accept && beat_last) state_next = ST_IDLE;
      end
      ST_DROP: begin
        drop_beat = 1'b1;
        if (accept && beat_last) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      sel_reg    <= '0;
      running    <= 1'b0;
      drop_count <= '0;
    end else begin
      state   <= state_next;
      sel_reg <= sel_next;
      running <= 1'b1;
      if (accept && drop_start && (drop_count != '1)) begin
        drop_count <= drop_count + 16'd1;
      end
    end
  end

  assign keep_in = KEEP_ENABLE ? s_axis_tkeep : '1;
  assign last_in = LAST_ENABLE ? s_axis_tlast : 1'b1;
  assign id_in   = ID_ENABLE ? s_axis_tid : '0;
  assign dest_in = s_axis_tdest[M_DEST_WIDTH-1:0];
  assign user_in = USER_ENABLE ? s_axis_tuser : '0;

  assign in_payload = {cur_sel, s_axis_tdata, keep_in, last_in, id_in, dest_in, user_in};

  axis_skid_reg #(
    .WIDTH(PW)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_payload),
    .in_valid (accept && !drop_beat),
    .ready_int(ready_int),
    .out_data (out_payload),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  assign {out_sel, out_tdata, out_tkeep, out_tlast, out_tid, out_tdest, out_tuser} = out_payload;

  always_comb begin
    m_axis_tvalid = '0;
    for (int unsigned k = 0; k < M_COUNT; k++) begin
      m_axis_tvalid[k] = out_valid && (out_sel == CL_M_COUNT'(k));
    end
  end

  assign out_ready = |(m_axis_tready & m_axis_tvalid);

  assign m_axis_tdata = {M_COUNT{out_tdata}};
  assign m_axis_tkeep = {M_COUNT{out_tkeep}};
  assign m_axis_tlast = {M_COUNT{out_tlast}};
  assign m_axis_tid   = {M_COUNT{out_tid}};
  assign m_axis_tdest = {M_COUNT{out_tdest}};
  assign m_axis_tuser = {M_COUNT{out_tuser}};

endmodule
